// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO push arbiter.
// The arbiter either sits idle and arbitrates each cycle, or holds the
// FIFO write port for one owner for a bounded burst.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  // The burst counter must be able to represent MAX_BURST itself, since the
  // count reaches that value on the final beat of a burst.
  function automatic int burstCntWidth(input int maxBurst);
    return $clog2(maxBurst + 1);
  endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Round-robin find-first helper for the FIFO push arbiter.
// Returns the first asserted request at or after ptr, wrapping modulo N_REQ.
// Works for any N_REQ, including values that are not a power of two.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rotated;
  logic [ID_W-1:0]  offset;

  // Modular add of two indices; one conditional subtraction is enough
  // because both operands are always below N_REQ.
  function automatic logic [ID_W-1:0] wrapAdd(input logic [ID_W-1:0] base,
                                              input logic [ID_W-1:0] off);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= (ID_W+1)'(N_REQ)) begin
      sum = sum - (ID_W+1)'(N_REQ);
    end
    return sum[ID_W-1:0];
  endfunction

  // Rotate the request vector so that bit 0 is the requester at ptr.
  always_comb begin
    rotated = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rotated[k] = req[wrapAdd(ptr, ID_W'(k))];
    end
  end

  // Find the lowest set bit of the rotated vector.
  always_comb begin
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rotated[k]) begin
        found  = 1'b1;
        offset = ID_W'(k);
      end
    end
  end

  // Undo the rotation to recover the absolute requester index.
  always_comb begin
    idx = wrapAdd(ptr, offset);
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO write port among N_REQ producers.
// Round-robin arbitration with bounded bursts; the grant path is purely
// combinational so a beat is pushed in the same cycle it is requested.
// A push is never issued while the FIFO reports full.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  input  logic                        fifo_full,
  output logic                        fifo_push,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        busy,
  output logic [ID_W-1:0]             owner_id
);

  localparam int              CNT_W    = burstCntWidth(MAX_BURST);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BURST);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  rrPtr_q, rrPtr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] beatCnt_q, beatCnt_d;
  logic             busy_q, busy_d;

  logic             ownerReq;
  logic             releaseNow;
  logic [ID_W-1:0]  pickPtr;
  logic             pickFound;
  logic [ID_W-1:0]  pickIdx;
  logic             arbitrate;
  logic [N_REQ-1:0] gntVec;

  // Increment an index with wrap at N_REQ-1 (not at a power of two).
  function automatic logic [ID_W-1:0] nextPtr(input logic [ID_W-1:0] p);
    if (p == ID_W'(N_REQ - 1)) begin
      return '0;
    end
    return p + ID_W'(1);
  endfunction

  // On release the search starts just past the old owner, so it ranks last.
  always_comb begin
    ownerReq   = req[owner_q];
    releaseNow = (state_q == ARB_BURST) && !ownerReq;
    pickPtr    = releaseNow ? nextPtr(owner_q) : rrPtr_q;
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rrPick (
    .req   (req),
    .ptr   (pickPtr),
    .found (pickFound),
    .idx   (pickIdx)
  );

  // Next-state and grant decision; a release re-arbitrates in the same cycle.
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    owner_d   = owner_q;
    beatCnt_d = beatCnt_q;
    gntVec    = '0;
    arbitrate = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        arbitrate = 1'b1;
      end
      ARB_BURST: begin
        if (ownerReq) begin
          if (!fifo_full && (beatCnt_q < MAX_CNT)) begin
            gntVec[owner_q] = 1'b1;
            beatCnt_d       = beatCnt_q + CNT_W'(1);
            if (beatCnt_q == LAST_CNT) begin
              rrPtr_d = nextPtr(owner_q);
              state_d = ARB_IDLE;
            end
          end
        end else begin
          rrPtr_d   = nextPtr(owner_q);
          state_d   = ARB_IDLE;
          arbitrate = 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (arbitrate && !fifo_full && pickFound) begin
      gntVec[pickIdx] = 1'b1;
      owner_d         = pickIdx;
      beatCnt_d       = CNT_W'(1);
      if (MAX_BURST == 1) begin
        rrPtr_d = nextPtr(pickIdx);
        state_d = ARB_IDLE;
      end else begin
        state_d = ARB_BURST;
      end
    end
  end

  // busy mirrors the next state so it is a clean registered flag.
  always_comb begin
    busy_d = (state_d == ARB_BURST);
  end

  // Arbiter state register; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      rrPtr_q   <= '0;
      owner_q   <= '0;
      beatCnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      owner_q   <= owner_d;
      beatCnt_q <= beatCnt_d;
      busy_q    <= busy_d;
    end
  end

  // Grants are suppressed during reset so nothing is pushed in that cycle.
  always_comb begin
    gnt       = reset ? '0 : gntVec;
    fifo_push = |gnt;
  end

  // AND-OR data mux over the one-hot grant; zero when nothing is granted.
  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_data = fifo_data |
                  (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
    end
  end

  assign busy     = busy_q;
  assign owner_id = owner_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter with a 16-deep FIFO model.
// Directed phases queue the hand-computed grant sequence; a negedge monitor
// pops and compares on every push. A final random phase checks invariants,
// lane data integrity and the starvation bound.
module tb_fifo_push_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 64;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int STARVE_MAX = (N_REQ - 1) * MAX_BURST;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [N_REQ-1:0]            req = '0;
  logic [N_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [N_REQ-1:0]            gnt;
  logic                        fifo_full;
  logic                        fifo_push;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic                        busy;
  logic [ID_W-1:0]             owner_id;

  logic forceFull = 1'b0;
  logic popEn = 1'b0;
  logic modelFull = 1'b0;
  assign fifo_full = modelFull | forceFull;

  typedef struct {
    int               lane;
    logic [63:0]      data;
  } exp_t;

  exp_t        expQ[$];
  logic [63:0] fifoQ[$];
  int          laneSeq[N_REQ];
  int          expSeq[N_REQ];
  int          waitCnt[N_REQ];
  logic [N_REQ-1:0] gntSeen = '0;
  bit          randomMode = 1'b0;
  int          checks = 0;
  int          passes = 0;

  fifo_push_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .ID_W       (ID_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .fifo_full (fifo_full),
    .fifo_push (fifo_push),
    .fifo_data (fifo_data),
    .busy      (busy),
    .owner_id  (owner_id)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] makeData(input int lane, input int seq);
    return {8'(lane), 24'hC0FFEE, 32'(seq)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveData();
    for (int i = 0; i < N_REQ; i++) begin
      req_data[i*DATA_WIDTH +: DATA_WIDTH] = makeData(i, laneSeq[i]);
    end
  endtask

  task automatic expectGrant(input int lane);
    exp_t e;
    e.lane = lane;
    e.data = makeData(lane, expSeq[lane]);
    expQ.push_back(e);
    expSeq[lane]++;
  endtask

  // One cycle: advance lanes whose beat was consumed, drive inputs just after
  // the edge, and return just after the monitor has sampled at negedge.
  task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] r,
                               input logic full, input logic pop);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (gntSeen[i]) laneSeq[i]++;
    end
    gntSeen   = '0;
    driveData();
    reset     = rst;
    req       = r;
    forceFull = full;
    popEn     = pop;
    @(negedge clk);
    #1;
  endtask

  // FIFO full flag follows the model occupancy at each clock edge.
  always @(posedge clk) begin
    modelFull <= (fifoQ.size() == FIFO_DEPTH);
  end

  // Monitor: invariants every cycle, scoreboard or random checks, FIFO model.
  always @(negedge clk) begin
    int worst;
    exp_t e;
    gntSeen = gnt;
    checkOutput("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    checkOutput("full_blocks_gnt", 64'(fifo_full && (gnt != '0)), 64'd0);
    checkOutput("push_is_or_gnt", 64'(fifo_push), 64'(|gnt));

    if (!randomMode) begin
      if (fifo_push || (expQ.size() != 0)) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_push", 64'(fifo_push), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("grant_lane", 64'({fifo_push, gnt}),
                      64'({1'b1, 4'(1 << e.lane)}));
          checkOutput("push_data", fifo_data, e.data);
        end
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && $onehot(gnt)) begin
          checkOutput("rand_data", fifo_data, makeData(i, laneSeq[i]));
        end
      end
      worst = 0;
      for (int i = 0; i < N_REQ; i++) begin
        if (reset || !req[i] || gnt[i]) waitCnt[i] = 0;
        else if (gnt != '0) waitCnt[i]++;
        if (waitCnt[i] > worst) worst = waitCnt[i];
      end
      checkOutput("starve_bound", 64'(worst <= STARVE_MAX), 64'd1);
    end

    if (popEn && (fifoQ.size() > 0)) void'(fifoQ.pop_front());
    if (fifo_push && !fifo_full) fifoQ.push_back(fifo_data);
  end

  initial begin
    int base;
    for (int i = 0; i < N_REQ; i++) begin
      laneSeq[i] = 0;
      expSeq[i]  = 0;
      waitCnt[i] = 0;
    end
    driveData();

    // Reset with all lanes requesting: nothing may be granted.
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b1);
    checkOutput("reset_gnt", 64'(gnt), 64'd0);
    checkOutput("reset_push", 64'(fifo_push), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_owner", 64'(owner_id), 64'd0);

    // All lanes requesting, FIFO drained: 4-beat bursts rotate with no bubble.
    for (int i = 0; i < 17; i++) begin
      expectGrant((i / 4) % 4);
      applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
    end
    checkOutput("rot_busy_idle", 64'(busy), 64'd0);
    checkOutput("rot_owner", 64'(owner_id), 64'd3);

    // Lane 2 alone for two beats, then drops; pointer lands on 3.
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("rel_busy", 64'(busy), 64'd1);
    checkOutput("rel_owner", 64'(owner_id), 64'd0);
    expectGrant(2);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1);
    checkOutput("l2_idle_busy", 64'(busy), 64'd0);
    expectGrant(2);
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b1);
    checkOutput("l2_busy", 64'(busy), 64'd1);
    checkOutput("l2_owner", 64'(owner_id), 64'd2);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("l2_busy_b2", 64'(busy), 64'd1);
    expectGrant(0);
    applyStimulus(1'b0, 4'b0101, 1'b0, 1'b1);
    checkOutput("l2_released", 64'(busy), 64'd0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("wrap_owner", 64'(owner_id), 64'd0);

    // No pops: exactly 16 lane-0 beats fill the FIFO, then grants stop.
    base = expSeq[0];
    for (int i = 0; i < 20; i++) begin
      if (i < FIFO_DEPTH) expectGrant(0);
      applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
    end
    checkOutput("fifo_level", 64'(fifoQ.size()), 64'(FIFO_DEPTH));
    checkOutput("fifo_full_flag", 64'(fifo_full), 64'd1);
    for (int j = 0; j < FIFO_DEPTH; j++) begin
      checkOutput("fifo_order", fifoQ[j], makeData(0, base + j));
    end

    // Drain the FIFO with no requests.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    end
    checkOutput("fifo_drained", 64'(fifoQ.size()), 64'd0);

    // Full mid-burst: lane 1 stalls at beat 2, finishes, then lane 3 wins.
    expectGrant(1);
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b1);
    expectGrant(1);
    applyStimulus(1'b0, 4'b0010, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b1011, 1'b1, 1'b1);
      checkOutput("stall_owner", 64'(owner_id), 64'd1);
      checkOutput("stall_busy", 64'(busy), 64'd1);
    end
    expectGrant(1);
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b1);
    expectGrant(1);
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b1);
    expectGrant(3);
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b1);
    expectGrant(3);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b1);
    checkOutput("l3_owner", 64'(owner_id), 64'd3);
    checkOutput("l3_busy", 64'(busy), 64'd1);

    // Reset during lane 3's burst: no push that cycle, fresh arbitration after.
    applyStimulus(1'b1, 4'b1000, 1'b0, 1'b1);
    checkOutput("midrst_gnt", 64'(gnt), 64'd0);
    checkOutput("midrst_push", 64'(fifo_push), 64'd0);
    expectGrant(3);
    applyStimulus(1'b0, 4'b1000, 1'b0, 1'b1);
    checkOutput("postrst_busy", 64'(busy), 64'd0);
    checkOutput("postrst_owner", 64'(owner_id), 64'd0);
    for (int i = 0; i < 3; i++) begin
      expectGrant(3);
      applyStimulus(1'b0, 4'b1000, 1'b0, 1'b1);
      checkOutput("postrst_burst_busy", 64'(busy), 64'd1);
      checkOutput("postrst_burst_owner", 64'(owner_id), 64'd3);
    end
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    checkOutput("postrst_burst_end", 64'(busy), 64'd0);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    // Random requests, full and pops; invariants and starvation bound.
    randomMode = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'b0, 4'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
